// File: rtl/snake_pkg.sv
// Shared heading definitions for the direction controller and the display/game logic.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package snake_pkg;

  // Heading encoding; bit 1 selects the axis (0 = vertical, 1 = horizontal).
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // A turn onto the same axis is either a repeat or a reversal; both are illegal.
  function automatic logic is_same_axis(input logic [1:0] a, input logic [1:0] b);
    return a[1] == b[1];
  endfunction

endpackage

// File: rtl/snake_turn_fifo.sv
// Small synchronous FIFO of 2-bit headings buffered between game ticks.
// Latency: push visible at head/tail the next cycle; pop advances head the next cycle.
// Backpressure: none internal; the caller must not push when full unless it pops in the same cycle.
//
// Ports: clk, reset (sync, active-high); push/push_dat write at tail; pop advances head;
//        head_dat = oldest entry; tail_dat = newest entry; count/full/empty = occupancy.
module snake_turn_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [1:0]                 push_dat,
  input  logic                       pop,
  output logic [1:0]                 head_dat,
  output logic [1:0]                 tail_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count_q, count_d;

  // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign tail_ptr = wr_ptr_q - 1'b1;
  assign head_dat = mem_q[rd_ptr_q];
  assign tail_dat = mem_q[tail_ptr];
  assign count    = count_q;
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);

endmodule

// File: rtl/snake_dir_ctrl.sv
// Turns debounced button presses into legal snake headings, queues them, releases one per tick.
// Latency: press -> queued next cycle; tick -> dir/dir_changed next cycle.
// Backpressure: full queue discards a legal press (drop pulse) unless a pop frees a slot that cycle.
//
// Ports: clk, reset (sync, active-high); btn_up/down/left/right debounced levels; enable gates
//        all activity; tick = game-step strobe; dir = heading; dir_changed / drop = one-cycle
//        pulses; q_count = queued turns.
module snake_dir_ctrl #(
  parameter int         QDEPTH   = 2,
  parameter logic [1:0] INIT_DIR = 2'd3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      btn_up,
  input  logic                      btn_down,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      enable,
  input  logic                      tick,
  output logic [1:0]                dir,
  output logic                      dir_changed,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      drop
);

  import snake_pkg::*;

  // Bit index matches the heading encoding: [0]=UP [1]=DOWN [2]=LEFT [3]=RIGHT.
  logic [3:0] btn;
  logic [3:0] prev_q, prev_d;
  logic [3:0] press;
  logic [1:0] dir_q, dir_d;
  logic       dir_changed_q, dir_changed_d;
  logic       drop_q, drop_d;

  logic       cand_vld;
  logic [1:0] cand;
  logic [1:0] ref_dir;
  logic       want_push, do_push, do_pop;
  logic [1:0] head_dat, tail_dat;
  logic       fifo_full, fifo_empty;

  assign btn   = {btn_right, btn_left, btn_down, btn_up};
  assign press = btn & ~prev_q;

  always_comb begin
    // Edge history follows the buttons even while disabled, so un-freezing never fires a stale press.
    prev_d = btn;

    cand_vld = |press;
    cand     = DIR_RIGHT;
    if (press[0])      cand = DIR_UP;
    else if (press[1]) cand = DIR_DOWN;
    else if (press[2]) cand = DIR_LEFT;

    // Legality is judged against where the snake will be heading once the queue drains,
    // using the pre-pop view of the queue.
    ref_dir = fifo_empty ? dir_q : tail_dat;

    do_pop    = enable & tick & ~fifo_empty;
    want_push = enable & cand_vld & ~is_same_axis(cand, ref_dir);
    do_push   = want_push & (~fifo_full | do_pop);

    dir_d         = do_pop ? head_dat : dir_q;
    dir_changed_d = do_pop;
    drop_d        = want_push & fifo_full & ~do_pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q        <= btn;
      dir_q         <= INIT_DIR;
      dir_changed_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      prev_q        <= prev_d;
      dir_q         <= dir_d;
      dir_changed_q <= dir_changed_d;
      drop_q        <= drop_d;
    end
  end

  snake_turn_fifo #(
    .DEPTH (QDEPTH)
  ) u_turn_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (do_push),
    .push_dat (cand),
    .pop      (do_pop),
    .head_dat (head_dat),
    .tail_dat (tail_dat),
    .count    (q_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign dir         = dir_q;
  assign dir_changed = dir_changed_q;
  assign drop        = drop_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl: expected dir_changed/drop events are queued by the
// stimulus and consumed by an independent monitor; queue depth and heading are spot-checked.
// Runs with QDEPTH = 2, INIT_DIR = RIGHT.
module tb_snake_dir_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       enable;
  logic       tick;
  logic [1:0] dir;
  logic       dir_changed;
  logic [1:0] q_count;
  logic       drop;

  typedef struct {
    bit         is_drop;
    logic [1:0] dir;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;

  snake_dir_ctrl #(
    .QDEPTH   (2),
    .INIT_DIR (2'd3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .enable      (enable),
    .tick        (tick),
    .dir         (dir),
    .dir_changed (dir_changed),
    .q_count     (q_count),
    .drop        (drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (dir_changed || drop) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: dir_changed=%0d drop=%0d dir=%0d, none expected",
                 dir_changed, drop, dir);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_is_drop", {31'd0, drop}, {31'd0, e.is_drop});
        check("event_dir_changed", {31'd0, dir_changed}, {31'd0, ~e.is_drop});
        if (!e.is_drop) check("event_dir", {30'd0, dir}, {30'd0, e.dir});
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mask bits: [0]=UP [1]=DOWN [2]=LEFT [3]=RIGHT; t drives tick in the press cycle.
  task automatic press(input logic [3:0] mask, input logic t = 1'b0);
    {btn_right, btn_left, btn_down, btn_up} = mask;
    tick = t;
    cyc();
    {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
    tick = 1'b0;
    cyc();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  function automatic ev_t turn(input logic [1:0] d);
    ev_t e;
    e.is_drop = 1'b0;
    e.dir     = d;
    return e;
  endfunction

  function automatic ev_t dropped();
    ev_t e;
    e.is_drop = 1'b1;
    e.dir     = 2'd0;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; tick = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(10);
    check("reset_dir", {30'd0, dir}, 32'd3);
    check("reset_qcount", {30'd0, q_count}, 32'd0);
    btn_right = 1'b0;
    cyc();

    // UP then tick five cycles later.
    press(4'b0001);
    check("up_qcount", {30'd0, q_count}, 32'd1);
    cyc(3);
    exp_q.push_back(turn(2'd0));
    do_tick();
    check("up_dir", {30'd0, dir}, 32'd0);
    check("up_qcount_after_tick", {30'd0, q_count}, 32'd0);
    cyc();
    check("up_pulse_one_cycle", {31'd0, dir_changed}, 32'd0);

    // Back to RIGHT.
    press(4'b1000);
    exp_q.push_back(turn(2'd3));
    do_tick();
    cyc();

    // LEFT and RIGHT are both on RIGHT's axis: silently rejected.
    press(4'b0100);
    press(4'b1000);
    check("same_axis_qcount", {30'd0, q_count}, 32'd0);
    do_tick();
    check("same_axis_dir", {30'd0, dir}, 32'd3);

    // Fill: UP, LEFT queued; DOWN dropped (queue full); RIGHT rejected against LEFT.
    press(4'b0001);
    press(4'b0100);
    check("fill_qcount", {30'd0, q_count}, 32'd2);
    exp_q.push_back(dropped());
    press(4'b0010);
    press(4'b1000);
    check("full_qcount", {30'd0, q_count}, 32'd2);

    // DOWN with a tick on the full queue [UP, LEFT]: pop and push both happen.
    exp_q.push_back(turn(2'd0));
    {btn_right, btn_left, btn_down, btn_up} = 4'b0010;
    tick = 1'b1;
    cyc();
    {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
    tick = 1'b0;
    check("pushpop_qcount", {30'd0, q_count}, 32'd2);
    check("pushpop_dir", {30'd0, dir}, 32'd0);
    cyc();
    exp_q.push_back(turn(2'd2));
    do_tick();
    exp_q.push_back(turn(2'd1));
    do_tick();
    check("drain_dir", {30'd0, dir}, 32'd1);
    check("drain_qcount", {30'd0, q_count}, 32'd0);
    cyc();

    // Return to RIGHT, then UP+LEFT together: UP wins.
    press(4'b1000);
    exp_q.push_back(turn(2'd3));
    do_tick();
    cyc();
    press(4'b0101);
    check("prio_qcount", {30'd0, q_count}, 32'd1);
    exp_q.push_back(turn(2'd0));
    do_tick();
    check("prio_dir", {30'd0, dir}, 32'd0);
    cyc();

    // Disabled: press and tick are ignored; the held press does not fire on re-enable.
    enable = 1'b0;
    btn_left = 1'b1;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    enable = 1'b1;
    cyc(2);
    btn_left = 1'b0;
    cyc();
    check("disabled_qcount", {30'd0, q_count}, 32'd0);
    check("disabled_dir", {30'd0, dir}, 32'd0);

    // Tick with empty queue plus a press in the same cycle: push lands, no pop yet.
    press(4'b0100, 1'b1);
    check("empty_pushpop_qcount", {30'd0, q_count}, 32'd1);
    check("empty_pushpop_dir", {30'd0, dir}, 32'd0);
    exp_q.push_back(turn(2'd2));
    do_tick();
    cyc();

    // Reset mid-operation with two queued turns and a tick pending.
    press(4'b0001);
    press(4'b1000);
    check("prereset_qcount", {30'd0, q_count}, 32'd2);
    reset = 1'b1;
    tick = 1'b1;
    cyc();
    reset = 1'b0;
    tick = 1'b0;
    check("midreset_qcount", {30'd0, q_count}, 32'd0);
    check("midreset_dir", {30'd0, dir}, 32'd3);
    cyc(4);

    check("events_outstanding", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Receiving end of the debounced button interface. Consumes the four stable button levels that the debouncer in snake_top produces.
- Converts presses into legal snake heading changes and buffers them in a small turn queue.
- Releases one queued turn per game-step tick to the display/game logic.
- Rejects 180-degree reversals and repeats so the snake can never fold onto itself, even with fast multi-press input between ticks.

Parameters:
- QDEPTH, 2, number of turn entries buffered between ticks (power of 2, 2..8).
- INIT_DIR, 2'd3, heading loaded at reset (RIGHT).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_up  input  1  debounced level, high = pressed.
- btn_down  input  1  debounced level.
- btn_left  input  1  debounced level.
- btn_right  input  1  debounced level.
- enable  input  1  game running; low freezes the block.
- tick  input  1  one-cycle game-step strobe.
- dir  output  2  current heading: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
- dir_changed  output  1  one-cycle pulse when dir updates.
- q_count  output  clog2(QDEPTH)+1  entries currently queued.
- drop  output  1  one-cycle pulse when an accepted-direction press is discarded because the queue is full.

Behaviour:
- All state is registered on posedge clk. Reset is synchronous and active-high.
- Reset values:
  - dir = INIT_DIR; dir_changed = 0; drop = 0; q_count = 0; queue pointers = 0.
  - Edge-detect registers load the current btn_* levels, so a button held through reset generates no press.
- Edge detect: press[i] = btn_i & ~prev_i. prev_i is updated every cycle, including when enable = 0.
- Arbitration: when more than one press occurs in the same cycle, priority is UP > DOWN > LEFT > RIGHT. Only the winner is considered; the others are lost.
- Reference heading = newest queue entry if q_count > 0, else dir. The value is taken before this cycle's pop.
- Legality: the candidate is rejected when cand[1] == ref[1] (same axis). This covers both a repeat and a reversal. Rejection is silent: no drop pulse.
- Push: a legal candidate with enable = 1 is written at the tail.
  - If the queue is full and no pop occurs this cycle, the entry is discarded and drop pulses the next cycle.
- Pop: tick = 1 with enable = 1 and q_count > 0 (pre-cycle value):
  - dir <= head entry, head advances.
  - dir_changed = 1 in the following cycle, aligned with the new dir value.
- tick with an empty queue: dir is held and dir_changed stays 0.
- Simultaneous push and pop:
  - Both take effect and q_count is unchanged.
  - A full queue accepts the push because the pop frees a slot; no drop.
- Simultaneous push and pop with an empty queue: no pop occurs. The push lands and is applied at the next tick, so latency is tick-to-tick.
- Pointers wrap modulo QDEPTH. q_count saturates at QDEPTH by construction.
- enable = 0:
  - No push, no pop, no drop pulse.
  - Queue contents and dir are held.
  - dir_changed and drop are forced to 0.
- Reset asserted mid-operation: the queue is flushed and dir returns to INIT_DIR on the next clock edge, regardless of tick or press in that cycle.

Decomposition:
- Shared package snake_pkg:
  - Direction encoding constants DIR_UP = 0, DIR_DOWN = 1, DIR_LEFT = 2, DIR_RIGHT = 3.
  - Function is_same_axis(a, b).
  - The display/game logic uses the same package.
- One natural sub-module: snake_turn_fifo, a QDEPTH-entry, 2-bit-wide synchronous FIFO.
  - Ports: push/pop, count, head, tail-peek, full/empty.
  - snake_dir_ctrl keeps edge detect, arbitration, legality and the dir register.

Test Plan:
- Reset with btn_right held high, then release reset and hold 10 cycles -> dir = 3, q_count = 0, no dir_changed, no drop.
- dir = 3: pulse btn_up, then tick 5 cycles later -> q_count = 1 after the press; on the cycle after tick, dir = 0 and dir_changed = 1 for exactly one cycle; q_count = 0.
- dir = 3: press LEFT, then press RIGHT, with no tick -> both rejected (same axis), q_count = 0. Next tick -> dir stays 3 and dir_changed = 0.
- QDEPTH = 2, dir = 3: press UP, LEFT, DOWN, RIGHT with no tick ->
  - UP and LEFT queued (q_count = 2).
  - DOWN is legal against LEFT, but the queue is full, so drop pulses once.
  - RIGHT is rejected against LEFT, with no drop.
  - Two ticks -> dir goes 0 then 2.
- Queue full [0, 2], DOWN press in the same cycle as tick -> pop and push both occur, q_count stays 2, no drop, dir = 0. Next two ticks -> dir = 2, then dir = 1.
- UP and LEFT pressed in the same cycle with dir = 3 -> only UP queued. Also: enable = 0 during a press and a tick -> nothing changes. Reset asserted with q_count = 2 -> q_count = 0 and dir = 3 the next cycle.
